// File: rtl/mvu_vvu_axis.sv
// Streaming MVU/VVU compute engine: SIMD-folded dot products per PE lane over
// AXI-Stream weights and activations; MVU mode reuses one buffered activation vector.
module mvu_vvu_axis #(
  parameter int IS_MVU             = 1,
  parameter int MW                 = 16,
  parameter int MH                 = 16,
  parameter int PE                 = 2,
  parameter int SIMD               = 4,
  parameter int ACTIVATION_WIDTH   = 4,
  parameter int WEIGHT_WIDTH       = 4,
  parameter int ACCU_WIDTH         = ACTIVATION_WIDTH + WEIGHT_WIDTH + $clog2(MW),
  parameter int SIGNED_ACTIVATIONS = 0,
  localparam int NF = (IS_MVU != 0) ? MH / PE : 1,
  localparam int SF = (IS_MVU != 0) ? MW / SIMD : MW / (SIMD * PE),
  localparam int AW = ((IS_MVU != 0) ? 1 : PE) * SIMD,
  localparam int WB = ((PE * SIMD * WEIGHT_WIDTH + 7) / 8) * 8,
  localparam int AB = ((AW * ACTIVATION_WIDTH + 7) / 8) * 8,
  localparam int OB = ((PE * ACCU_WIDTH + 7) / 8) * 8
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic [WB-1:0] s_axis_weights_tdata,
  input  logic          s_axis_weights_tvalid,
  output logic          s_axis_weights_tready,
  input  logic [AB-1:0] s_axis_input_tdata,
  input  logic          s_axis_input_tvalid,
  output logic          s_axis_input_tready,
  output logic [OB-1:0] m_axis_output_tdata,
  output logic          m_axis_output_tvalid,
  input  logic          m_axis_output_tready
);
  localparam int SFW = (SF > 1) ? $clog2(SF) : 1;
  localparam int NFW = (NF > 1) ? $clog2(NF) : 1;
  localparam int WL  = PE * SIMD * WEIGHT_WIDTH;
  localparam int AL  = AW * ACTIVATION_WIDTH;
  localparam int OL  = PE * ACCU_WIDTH;

  if (MW % SIMD != 0) begin : g_err_simd
    $error("MW must be a multiple of SIMD");
  end
  if (IS_MVU != 0 && MH % PE != 0) begin : g_err_pe
    $error("MH must be a multiple of PE");
  end
  if (IS_MVU == 0 && MW % (SIMD * PE) != 0) begin : g_err_vvu
    $error("MW must be a multiple of SIMD*PE in VVU mode");
  end

  function automatic logic signed [ACCU_WIDTH-1:0] ext_w(input logic [WEIGHT_WIDTH-1:0] v);
    return {{(ACCU_WIDTH-WEIGHT_WIDTH){v[WEIGHT_WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [ACCU_WIDTH-1:0] ext_a(input logic [ACTIVATION_WIDTH-1:0] v);
    logic msb;
    msb = (SIGNED_ACTIVATIONS != 0) && v[ACTIVATION_WIDTH-1];
    return {{(ACCU_WIDTH-ACTIVATION_WIDTH){msb}}, v};
  endfunction

  // VVU activations are interleaved across lanes: element k + l*PE feeds lane k
  function automatic int act_idx(input int k, input int l);
    return (IS_MVU != 0) ? l : k + l * PE;
  endfunction

  logic [SFW-1:0] sf;
  logic [NFW-1:0] nf;
  logic           en, step, first_nf;
  logic [AL-1:0]  act_cur;
  logic           unused_bits;

  assign unused_bits = &{1'b0, s_axis_weights_tdata, s_axis_input_tdata};
  assign first_nf = (nf == '0);
  assign en       = !(m_axis_output_tvalid && !m_axis_output_tready);
  assign s_axis_weights_tready = !ap_rst && en && (!first_nf || s_axis_input_tvalid);
  assign s_axis_input_tready   = !ap_rst && en && first_nf && s_axis_weights_tvalid;
  assign step = s_axis_weights_tready && s_axis_weights_tvalid;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      sf <= '0;
      nf <= '0;
    end else if (step) begin
      if (sf == SFW'(SF - 1)) begin
        sf <= '0;
        nf <= (nf == NFW'(NF - 1)) ? '0 : nf + 1'b1;
      end else begin
        sf <= sf + 1'b1;
      end
    end
  end

  if (IS_MVU != 0) begin : g_buf
    logic [AL-1:0] abuf [SF];
    always_ff @(posedge ap_clk) begin
      if (step && first_nf) abuf[sf] <= s_axis_input_tdata[AL-1:0];
    end
    assign act_cur = first_nf ? s_axis_input_tdata[AL-1:0] : abuf[sf];
  end else begin : g_nobuf
    assign act_cur = s_axis_input_tdata[AL-1:0];
  end

  logic                         s1_valid, s1_first, s1_last;
  logic [WL-1:0]                s1_w;
  logic [AL-1:0]                s1_a;
  logic signed [ACCU_WIDTH-1:0] dot [PE];
  logic                         s2_valid, s2_first, s2_last;
  logic signed [ACCU_WIDTH-1:0] s2_dot [PE];
  logic signed [ACCU_WIDTH-1:0] acc [PE];
  logic                         acc_done;
  logic [OL-1:0]                acc_flat;

  always_comb begin
    for (int k = 0; k < PE; k++) begin
      dot[k] = '0;
      for (int l = 0; l < SIMD; l++) begin
        dot[k] = dot[k]
               + ext_w(s1_w[(k*SIMD+l)*WEIGHT_WIDTH +: WEIGHT_WIDTH])
               * ext_a(s1_a[act_idx(k, l)*ACTIVATION_WIDTH +: ACTIVATION_WIDTH]);
      end
    end
  end

  always_comb begin
    acc_flat = '0;
    for (int k = 0; k < PE; k++) acc_flat[k*ACCU_WIDTH +: ACCU_WIDTH] = acc[k];
  end

  // Every stage advances only when the output register can accept, so a stall freezes all
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_w     <= '0;
      s1_a     <= '0;
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      acc_done <= 1'b0;
      for (int k = 0; k < PE; k++) begin
        s2_dot[k] <= '0;
        acc[k]    <= '0;
      end
      m_axis_output_tvalid <= 1'b0;
      m_axis_output_tdata  <= '0;
    end else if (en) begin
      s1_valid <= step;
      s1_first <= (sf == '0);
      s1_last  <= (sf == SFW'(SF - 1));
      s1_w     <= s_axis_weights_tdata[WL-1:0];
      s1_a     <= act_cur;
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      for (int k = 0; k < PE; k++) s2_dot[k] <= dot[k];
      acc_done <= s2_valid && s2_last;
      if (s2_valid) begin
        for (int k = 0; k < PE; k++) acc[k] <= s2_first ? s2_dot[k] : acc[k] + s2_dot[k];
      end
      m_axis_output_tvalid <= acc_done;
      if (acc_done) m_axis_output_tdata <= OB'(acc_flat);
    end
  end

endmodule

// File: tb/tb_mvu_vvu_axis.sv
// Scoreboard bench for mvu_vvu_axis: an MVU instance (NF=4, SF=3, unsigned acts)
// and a VVU instance (SF=1, signed acts) share clock and reset.
module tb_mvu_vvu_axis;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] mw_data = '0;
  logic        mw_valid = 1'b0, mw_ready;
  logic [7:0]  ma_data = '0;
  logic        ma_valid = 1'b0, ma_ready;
  logic [23:0] mo_data;
  logic        mo_valid, mo_ready = 1'b1;
  logic [15:0] vw_data = '0;
  logic        vw_valid = 1'b0, vw_ready;
  logic [15:0] va_data = '0;
  logic        va_valid = 1'b0, va_ready;
  logic [23:0] vo_data;
  logic        vo_valid, vo_ready = 1'b1;

  mvu_vvu_axis #(.IS_MVU(1), .MW(6), .MH(8), .PE(2), .SIMD(2), .ACTIVATION_WIDTH(4),
                 .WEIGHT_WIDTH(4), .SIGNED_ACTIVATIONS(0)) u_mvu (
    .ap_clk(clk), .ap_rst(rst),
    .s_axis_weights_tdata(mw_data), .s_axis_weights_tvalid(mw_valid), .s_axis_weights_tready(mw_ready),
    .s_axis_input_tdata(ma_data), .s_axis_input_tvalid(ma_valid), .s_axis_input_tready(ma_ready),
    .m_axis_output_tdata(mo_data), .m_axis_output_tvalid(mo_valid), .m_axis_output_tready(mo_ready));

  mvu_vvu_axis #(.IS_MVU(0), .MW(4), .MH(4), .PE(2), .SIMD(2), .ACTIVATION_WIDTH(4),
                 .WEIGHT_WIDTH(4), .SIGNED_ACTIVATIONS(1)) u_vvu (
    .ap_clk(clk), .ap_rst(rst),
    .s_axis_weights_tdata(vw_data), .s_axis_weights_tvalid(vw_valid), .s_axis_weights_tready(vw_ready),
    .s_axis_input_tdata(va_data), .s_axis_input_tvalid(va_valid), .s_axis_input_tready(va_ready),
    .m_axis_output_tdata(vo_data), .m_axis_output_tvalid(vo_valid), .m_axis_output_tready(vo_ready));

  int n_cmp = 0, n_bad = 0;
  logic [23:0] exp_m[$], exp_v[$];
  logic [23:0] em, ev;
  bit stall_hold = 0, rnd_rdy = 0, send_done = 0;
  int ma[3][2];
  int mw[4][3][2][2];
  int va[4];
  int vw[2][2];

  always @(posedge clk) begin
    #1;
    mo_ready = stall_hold ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    vo_ready = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  always @(negedge clk) begin
    if (mo_valid && mo_ready) begin
      n_cmp++;
      if (exp_m.size() == 0) begin
        n_bad++;
        $display("FAIL mvu_unexpected got=%h required=none", mo_data);
      end else begin
        em = exp_m.pop_front();
        if (mo_data !== em) begin
          n_bad++;
          $display("FAIL mvu_out got=%h required=%h", mo_data, em);
        end
      end
    end
    if (vo_valid && vo_ready) begin
      n_cmp++;
      if (exp_v.size() == 0) begin
        n_bad++;
        $display("FAIL vvu_unexpected got=%h required=none", vo_data);
      end else begin
        ev = exp_v.pop_front();
        if (vo_data !== ev) begin
          n_bad++;
          $display("FAIL vvu_out got=%h required=%h", vo_data, ev);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [23:0] got, input logic [23:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] m_lanes(input int l0, input int l1);
    logic [23:0] e;
    e = '0;
    e[10:0]  = l0[10:0];
    e[21:11] = l1[10:0];
    return e;
  endfunction

  function automatic logic [23:0] v_lanes(input int l0, input int l1);
    logic [23:0] e;
    e = '0;
    e[9:0]   = l0[9:0];
    e[19:10] = l1[9:0];
    return e;
  endfunction

  function automatic logic [15:0] pack_mw(input int nf, input int sf);
    logic [15:0] d;
    int t;
    d = '0;
    for (int k = 0; k < 2; k++)
      for (int l = 0; l < 2; l++) begin
        t = mw[nf][sf][k][l];
        d[(k*2+l)*4 +: 4] = t[3:0];
      end
    return d;
  endfunction

  function automatic logic [7:0] pack_ma(input int sf);
    logic [7:0] d;
    int t;
    d = '0;
    for (int l = 0; l < 2; l++) begin
      t = ma[sf][l];
      d[l*4 +: 4] = t[3:0];
    end
    return d;
  endfunction

  function automatic logic [15:0] pack_vw();
    logic [15:0] d;
    int t;
    d = '0;
    for (int k = 0; k < 2; k++)
      for (int l = 0; l < 2; l++) begin
        t = vw[k][l];
        d[(k*2+l)*4 +: 4] = t[3:0];
      end
    return d;
  endfunction

  function automatic logic [15:0] pack_va();
    logic [15:0] d;
    int t;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      t = va[i];
      d[i*4 +: 4] = t[3:0];
    end
    return d;
  endfunction

  task automatic drv_mw(input logic [15:0] d, input bit gaps);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    mw_data = d; mw_valid = 1'b1;
    @(negedge clk);
    while (!mw_ready && t < 200) begin @(negedge clk); t++; end
    if (!mw_ready) begin n_cmp++; n_bad++; $display("FAIL mw_timeout ready=%b required=1", mw_ready); end
    @(posedge clk); #1;
    mw_valid = 1'b0;
  endtask

  task automatic drv_ma(input logic [7:0] d, input bit gaps);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    ma_data = d; ma_valid = 1'b1;
    @(negedge clk);
    while (!ma_ready && t < 200) begin @(negedge clk); t++; end
    if (!ma_ready) begin n_cmp++; n_bad++; $display("FAIL ma_timeout ready=%b required=1", ma_ready); end
    @(posedge clk); #1;
    ma_valid = 1'b0;
  endtask

  task automatic drv_vw(input logic [15:0] d, input bit gaps);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    vw_data = d; vw_valid = 1'b1;
    @(negedge clk);
    while (!vw_ready && t < 200) begin @(negedge clk); t++; end
    if (!vw_ready) begin n_cmp++; n_bad++; $display("FAIL vw_timeout ready=%b required=1", vw_ready); end
    @(posedge clk); #1;
    vw_valid = 1'b0;
  endtask

  task automatic drv_va(input logic [15:0] d, input bit gaps);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    va_data = d; va_valid = 1'b1;
    @(negedge clk);
    while (!va_ready && t < 200) begin @(negedge clk); t++; end
    if (!va_ready) begin n_cmp++; n_bad++; $display("FAIL va_timeout ready=%b required=1", va_ready); end
    @(posedge clk); #1;
    va_valid = 1'b0;
  endtask

  // mode 0: constant acts/weights, 1: random, 2: acts 1..6 with constant weights
  task automatic mvu_fill(input int mode, input int a_c, input int w_c);
    for (int s = 0; s < 3; s++)
      for (int l = 0; l < 2; l++)
        ma[s][l] = (mode == 1) ? int'($urandom_range(0, 15)) : (mode == 2) ? s*2 + l + 1 : a_c;
    for (int n = 0; n < 4; n++)
      for (int s = 0; s < 3; s++)
        for (int k = 0; k < 2; k++)
          for (int l = 0; l < 2; l++)
            mw[n][s][k][l] = (mode == 1) ? int'($urandom_range(0, 15)) - 8 : w_c;
  endtask

  task automatic mvu_model();
    for (int n = 0; n < 4; n++) begin
      int s0, s1;
      s0 = 0; s1 = 0;
      for (int s = 0; s < 3; s++)
        for (int l = 0; l < 2; l++) begin
          s0 += ma[s][l] * mw[n][s][0][l];
          s1 += ma[s][l] * mw[n][s][1][l];
        end
      exp_m.push_back(m_lanes(s0, s1));
    end
  endtask

  task automatic mvu_send(input bit gaps);
    fork
      for (int b = 0; b < 12; b++) drv_mw(pack_mw(b / 3, b % 3), gaps);
      for (int s = 0; s < 3; s++) drv_ma(pack_ma(s), gaps);
    join
  endtask

  task automatic vvu_send(input bit gaps);
    fork
      drv_vw(pack_vw(), gaps);
      drv_va(pack_va(), gaps);
    join
  endtask

  task automatic vvu_vec(input int a0, input int a1, input int a2, input int a3,
                         input int w00, input int w01, input int w10, input int w11,
                         input int l0, input int l1);
    va[0] = a0; va[1] = a1; va[2] = a2; va[3] = a3;
    vw[0][0] = w00; vw[0][1] = w01; vw[1][0] = w10; vw[1][1] = w11;
    exp_v.push_back(v_lanes(l0, l1));
    vvu_send(0);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_m.size() != 0 || exp_v.size() != 0) && t < 1000) begin @(negedge clk); t++; end
    chk("drain_pending", 24'(exp_m.size() + exp_v.size()), 24'd0);
    repeat (6) @(negedge clk);
    sync();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    mw_valid = 1'b1; ma_valid = 1'b1; vw_valid = 1'b1; va_valid = 1'b1;
    @(negedge clk);
    chk("rst_mw_ready", mw_ready, 0);
    chk("rst_ma_ready", ma_ready, 0);
    chk("rst_mo_valid", mo_valid, 0);
    chk("rst_mo_data", mo_data, 0);
    chk("rst_vw_ready", vw_ready, 0);
    chk("rst_va_ready", va_ready, 0);
    chk("rst_vo_valid", vo_valid, 0);
    chk("rst_vo_data", vo_data, 0);
    sync();
    mw_valid = 1'b0; ma_valid = 1'b0; vw_valid = 1'b0; va_valid = 1'b0;
    rst = 1'b0;
    sync();

    // MVU directed, hand-computed: 6 products per lane
    mvu_fill(0, 15, -1);
    repeat (4) exp_m.push_back(m_lanes(-90, -90));
    mvu_send(0);
    mvu_fill(0, 15, -8);
    repeat (4) exp_m.push_back(m_lanes(-720, -720));
    mvu_send(0);
    mvu_fill(0, 15, 7);
    repeat (4) exp_m.push_back(m_lanes(630, 630));
    mvu_send(0);
    mvu_fill(2, 0, 1);
    repeat (4) exp_m.push_back(m_lanes(21, 21));
    mvu_send(0);

    // VVU directed with signed activations, back to back
    vvu_vec(1, 2, 3, 4, 1, 1, 1, 0, 4, 2);
    vvu_vec(-1, -1, -1, -1, -1, -1, -1, -1, 2, 2);
    vvu_vec(-8, 7, -8, 7, -8, -8, 7, 7, 128, 98);
    vvu_vec(3, -2, 5, -1, 2, -3, -4, 6, -9, 2);
    wait_drain();

    // random data with random valid gaps and ready backpressure
    rnd_rdy = 1;
    for (int i = 0; i < 6; i++) begin
      mvu_fill(1, 0, 0);
      mvu_model();
      mvu_send(1);
    end
    for (int i = 0; i < 8; i++) begin
      int s0, s1;
      for (int j = 0; j < 4; j++) va[j] = int'($urandom_range(0, 15)) - 8;
      for (int k = 0; k < 2; k++)
        for (int l = 0; l < 2; l++) vw[k][l] = int'($urandom_range(0, 15)) - 8;
      s0 = va[0] * vw[0][0] + va[2] * vw[0][1];
      s1 = va[1] * vw[1][0] + va[3] * vw[1][1];
      exp_v.push_back(v_lanes(s0, s1));
      vvu_send(1);
    end
    wait_drain();
    rnd_rdy = 0;

    // output backpressure: pipeline must freeze with weights still offered
    stall_hold = 1;
    sync();
    mvu_fill(1, 0, 0);
    mvu_model();
    send_done = 0;
    fork
      begin mvu_send(0); send_done = 1; end
    join_none
    t = 0;
    @(negedge clk);
    while (!mo_valid && t < 60) begin @(negedge clk); t++; end
    chk("stall_valid_rise", mo_valid, 1);
    em = mo_data;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stall_valid", mo_valid, 1);
      chk("stall_data", mo_data, em);
      chk("stall_mw_ready", mw_ready & mw_valid, 0);
      chk("stall_ma_ready", ma_ready, 0);
    end
    chk("stall_mw_offered", mw_valid, 1);
    stall_hold = 0;
    t = 0;
    while (!send_done && t < 400) begin @(negedge clk); t++; end
    chk("stall_send_done", send_done, 1);
    wait_drain();

    // reset in the middle of a vector, then a clean full vector
    mvu_fill(1, 0, 0);
    fork
      begin drv_mw(pack_mw(0, 0), 0); drv_mw(pack_mw(0, 1), 0); end
      begin drv_ma(pack_ma(0), 0); drv_ma(pack_ma(1), 0); end
    join
    rst = 1'b1;
    mw_valid = 1'b1; ma_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_mo_valid", mo_valid, 0);
    chk("midrst_mo_data", mo_data, 0);
    chk("midrst_mw_ready", mw_ready, 0);
    chk("midrst_ma_ready", ma_ready, 0);
    sync();
    mw_valid = 1'b0; ma_valid = 1'b0;
    rst = 1'b0;
    sync();
    mvu_fill(1, 0, 0);
    mvu_model();
    mvu_send(0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
